// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage: pass-through, single-outstanding load/store bus
module mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_rd_ena,
  input  logic [XLEN-1:0] in_rd_data,
  output logic            stall,
  output logic            req_valid,
  output logic            req_wen,
  output logic [XLEN-1:0] req_addr,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wstrb,
  input  logic            req_ready,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic            rd_data_mem_ena,
  output logic [XLEN-1:0] mem_r_data,
  output logic            rd_data_exe_ena,
  output logic [XLEN-1:0] rd_data_exe,
  output logic            misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic [2:0]      r_funct3;
  logic [2:0]      r_off;
  logic            r_rd_ena;
  logic            r_is_store;
  logic [XLEN-1:0] r_req_addr;
  logic [XLEN-1:0] r_req_wdata;
  logic [7:0]      r_req_wstrb;
  logic            r_mem_ena;
  logic [XLEN-1:0] r_mem_data;
  logic            r_exe_ena;
  logic [XLEN-1:0] r_exe_data;
  logic            r_misalign;

  logic            w_in_mem;
  logic [2:0]      w_in_off;
  logic            w_in_misalign;
  logic [7:0]      w_base_strb;
  logic [7:0]      w_in_strb;
  logic [XLEN-1:0] w_in_wdata;
  logic [XLEN-1:0] w_rsp_shift;
  logic [XLEN-1:0] w_load_data;

  assign w_in_mem   = in_load | in_store;
  assign w_in_off   = in_addr[2:0];
  assign w_in_strb  = w_base_strb << w_in_off;
  assign w_in_wdata = in_wdata << {w_in_off, 3'b000};

  // Size decode of the incoming op: alignment check and base byte-enable pattern.
  // funct3[1:0]==2'b11 covers both D and the unused 111 encoding.
  always_comb begin
    w_in_misalign = 1'b0;
    w_base_strb   = 8'hFF;
    case (in_funct3[1:0])
      2'b00: begin w_in_misalign = 1'b0;           w_base_strb = 8'h01; end
      2'b01: begin w_in_misalign = in_addr[0];     w_base_strb = 8'h03; end
      2'b10: begin w_in_misalign = |in_addr[1:0];  w_base_strb = 8'h0F; end
      default: begin w_in_misalign = |in_addr[2:0]; w_base_strb = 8'hFF; end
    endcase
  end

  // Select and extend the addressed bytes of the returned 8-byte line.
  always_comb begin
    w_rsp_shift = rsp_rdata >> {r_off, 3'b000};
    w_load_data = w_rsp_shift;
    case (r_funct3)
      3'b000:  w_load_data = {{56{w_rsp_shift[7]}},  w_rsp_shift[7:0]};
      3'b001:  w_load_data = {{48{w_rsp_shift[15]}}, w_rsp_shift[15:0]};
      3'b010:  w_load_data = {{32{w_rsp_shift[31]}}, w_rsp_shift[31:0]};
      3'b100:  w_load_data = {56'd0, w_rsp_shift[7:0]};
      3'b101:  w_load_data = {48'd0, w_rsp_shift[15:0]};
      3'b110:  w_load_data = {32'd0, w_rsp_shift[31:0]};
      default: w_load_data = w_rsp_shift;
    endcase
  end

  // Access FSM; enables are pulses, data registers hold their last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_funct3    <= 3'd0;
      r_off       <= 3'd0;
      r_rd_ena    <= 1'b0;
      r_is_store  <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wstrb <= 8'd0;
      r_mem_ena   <= 1'b0;
      r_mem_data  <= '0;
      r_exe_ena   <= 1'b0;
      r_exe_data  <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_mem_ena  <= 1'b0;
      r_exe_ena  <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (!w_in_mem) begin
              r_exe_ena  <= in_rd_ena;
              r_exe_data <= in_rd_data;
            end else if (w_in_misalign) begin
              r_misalign <= 1'b1;
            end else begin
              r_funct3    <= in_funct3;
              r_off       <= w_in_off;
              r_rd_ena    <= in_rd_ena;
              r_is_store  <= in_store;
              r_req_addr  <= {in_addr[XLEN-1:3], 3'b000};
              r_req_wdata <= w_in_wdata;
              r_req_wstrb <= in_store ? w_in_strb : 8'd0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (req_ready) r_state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_valid) begin
            if (!r_is_store) begin
              r_mem_data <= w_load_data;
              r_mem_ena  <= r_rd_ena;
            end
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall           = (r_state != S_IDLE);
  assign req_valid       = (r_state == S_REQ);
  assign req_wen         = r_is_store;
  assign req_addr        = r_req_addr;
  assign req_wdata       = r_req_wdata;
  assign req_wstrb       = r_req_wstrb;
  assign rd_data_mem_ena = r_mem_ena;
  assign mem_r_data      = r_mem_data;
  assign rd_data_exe_ena = r_exe_ena;
  assign rd_data_exe     = r_exe_data;
  assign misalign        = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, corner sequences, random ops
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_load, in_store, in_rd_ena;
  logic [2:0]  in_funct3;
  logic [63:0] in_addr, in_wdata, in_rd_data;
  logic        stall, req_valid, req_wen, req_ready, rsp_valid;
  logic [63:0] req_addr, req_wdata, rsp_rdata, mem_r_data, rd_data_exe;
  logic [7:0]  req_wstrb;
  logic        rd_data_mem_ena, rd_data_exe_ena, misalign;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_mem = 64'd0;
  logic [63:0] exp_exe = 64'd0;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd_ena(in_rd_ena), .in_rd_data(in_rd_data),
    .stall(stall), .req_valid(req_valid), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rd_data_mem_ena(rd_data_mem_ena), .mem_r_data(mem_r_data),
    .rd_data_exe_ena(rd_data_exe_ena), .rd_data_exe(rd_data_exe),
    .misalign(misalign)
  );

  typedef struct {
    logic        load;
    logic        store;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rd_ena;
    logic [63:0] rd_data;
    int          rdy_dly;
    int          rsp_dly;
    logic [63:0] rdata;
    logic [63:0] exp_addr;
    logic [7:0]  exp_wstrb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rd;
    logic        exp_mis;
  } rec_t;

  rec_t tbl[13];

  function automatic rec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic rd_ena, input logic [63:0] rd_data,
                              input int rdy, input int rsp, input logic [63:0] rdata,
                              input logic [63:0] e_addr, input logic [7:0] e_strb,
                              input logic [63:0] e_wdata, input logic [63:0] e_rd,
                              input logic e_mis);
    rec_t r;
    r.load = ld; r.store = st; r.f3 = f3; r.addr = addr; r.wdata = wdata;
    r.rd_ena = rd_ena; r.rd_data = rd_data; r.rdy_dly = rdy; r.rsp_dly = rsp;
    r.rdata = rdata; r.exp_addr = e_addr; r.exp_wstrb = e_strb;
    r.exp_wdata = e_wdata; r.exp_rd = e_rd; r.exp_mis = e_mis;
    return r;
  endfunction

  // Reference model: access size in bytes from the RV funct3 encoding.
  function automatic int m_nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  // Reference model: gather the addressed bytes, then extend.
  function automatic logic [63:0] m_load(input logic [2:0] f3, input int off, input logic [63:0] line);
    logic [63:0] v;
    int n;
    bit sgn;
    v = 64'd0;
    n = m_nbytes(f3);
    sgn = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    for (int i = 0; i < n; i++) v[8*i +: 8] = line[8*(off+i) +: 8];
    if (sgn && n < 8 && v[8*n-1])
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input int off);
    logic [7:0] s;
    s = 8'd0;
    for (int i = 0; i < m_nbytes(f3); i++) if (off + i < 8) s[off+i] = 1'b1;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Present one op in IDLE and walk it through to its result cycle.
  task automatic do_op(input rec_t r, input string tag);
    logic is_mem;
    is_mem = r.load | r.store;
    chk({tag, " idle_stall"}, {63'd0, stall}, 64'd0);
    in_valid = 1'b1; in_load = r.load; in_store = r.store; in_funct3 = r.f3;
    in_addr = r.addr; in_wdata = r.wdata; in_rd_ena = r.rd_ena; in_rd_data = r.rd_data;
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    in_addr = {$urandom, $urandom}; in_rd_data = {$urandom, $urandom};
    if (!is_mem) begin
      exp_exe = r.rd_data;
      chk({tag, " exe_ena"},  {63'd0, rd_data_exe_ena}, {63'd0, r.rd_ena});
      chk({tag, " exe_data"}, rd_data_exe, exp_exe);
      chk({tag, " pass_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, " pass_mem_ena"}, {63'd0, rd_data_mem_ena}, 64'd0);
    end else if (r.exp_mis) begin
      chk({tag, " misalign"}, {63'd0, misalign}, 64'd1);
      chk({tag, " mis_req"}, {63'd0, req_valid}, 64'd0);
      chk({tag, " mis_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, " mis_ena"}, {62'd0, rd_data_mem_ena, rd_data_exe_ena}, 64'd0);
      @(posedge clk); #1;
      chk({tag, " mis_pulse_end"}, {63'd0, misalign}, 64'd0);
      chk({tag, " mis_req2"}, {63'd0, req_valid}, 64'd0);
    end else begin
      for (int k = 0; k <= r.rdy_dly; k++) begin
        chk({tag, " req_valid"}, {63'd0, req_valid}, 64'd1);
        chk({tag, " req_stall"}, {63'd0, stall}, 64'd1);
        chk({tag, " req_addr"}, req_addr, r.exp_addr);
        chk({tag, " req_wen"}, {63'd0, req_wen}, {63'd0, r.store});
        if (r.store) begin
          chk({tag, " req_wstrb"}, {56'd0, req_wstrb}, {56'd0, r.exp_wstrb});
          chk({tag, " req_wdata"}, req_wdata, r.exp_wdata);
        end
        chk({tag, " req_ena"}, {61'd0, rd_data_mem_ena, rd_data_exe_ena, misalign}, 64'd0);
        rsp_valid = 1'($urandom % 2);
        rsp_rdata = {$urandom, $urandom};
        req_ready = (k == r.rdy_dly);
        @(posedge clk); #1;
        req_ready = 1'b0; rsp_valid = 1'b0;
      end
      for (int k = 0; k <= r.rsp_dly; k++) begin
        chk({tag, " resp_req_valid"}, {63'd0, req_valid}, 64'd0);
        chk({tag, " resp_stall"}, {63'd0, stall}, 64'd1);
        chk({tag, " resp_ena"}, {63'd0, rd_data_mem_ena}, 64'd0);
        req_ready = 1'($urandom % 2);
        rsp_valid = (k == r.rsp_dly);
        rsp_rdata = (k == r.rsp_dly) ? r.rdata : {$urandom, $urandom};
        @(posedge clk); #1;
        req_ready = 1'b0; rsp_valid = 1'b0;
      end
      if (r.load) exp_mem = r.exp_rd;
      chk({tag, " done_stall"}, {63'd0, stall}, 64'd0);
      chk({tag, " done_req_valid"}, {63'd0, req_valid}, 64'd0);
      chk({tag, " mem_ena"}, {63'd0, rd_data_mem_ena}, {63'd0, r.load & r.rd_ena});
      chk({tag, " mem_r_data"}, mem_r_data, exp_mem);
      chk({tag, " exe_ena_quiet"}, {63'd0, rd_data_exe_ena}, 64'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stall"}, {63'd0, stall}, 64'd0);
    chk({tag, " req_flags"}, {62'd0, req_valid, req_wen}, 64'd0);
    chk({tag, " req_addr"}, req_addr, 64'd0);
    chk({tag, " req_wdata"}, req_wdata, 64'd0);
    chk({tag, " req_wstrb"}, {56'd0, req_wstrb}, 64'd0);
    chk({tag, " enables"}, {61'd0, rd_data_mem_ena, rd_data_exe_ena, misalign}, 64'd0);
    chk({tag, " mem_r_data"}, mem_r_data, 64'd0);
    chk({tag, " rd_data_exe"}, rd_data_exe, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t r;
    int kind, n, off;
    rst = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_funct3 = 3'd0;
    in_addr = 64'd0; in_wdata = 64'd0; in_rd_ena = 1'b0; in_rd_data = 64'd0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 64'd0;

    //              ld st f3    addr         wdata        rde rd_data  rdy rsp rdata                  e_addr       e_strb e_wdata                e_rd                   mis
    tbl[0]  = mk(0, 0, 3'd0, 64'h0,      64'h0,        1, 64'h1234, 0, 0, 64'h0,                 64'h0,      8'h00, 64'h0,                 64'h1234,              0);
    tbl[1]  = mk(1, 0, 3'd0, 64'h1003,   64'h0,        1, 64'h0,    0, 0, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 0);
    tbl[2]  = mk(1, 0, 3'd4, 64'h1003,   64'h0,        1, 64'h0,    0, 0, 64'h0000_0000_8000_0000, 64'h1000, 8'h00, 64'h0,                 64'h80,                0);
    tbl[3]  = mk(0, 1, 3'd1, 64'h2006,   64'hBEEF,     0, 64'h0,    0, 0, 64'h0,                 64'h2000,   8'hC0, 64'hBEEF_0000_0000_0000, 64'h0,               0);
    tbl[4]  = mk(1, 0, 3'd3, 64'h4000,   64'h0,        1, 64'h0,    3, 2, 64'h0123_4567_89AB_CDEF, 64'h4000, 8'h00, 64'h0,                 64'h0123_4567_89AB_CDEF, 0);
    tbl[5]  = mk(1, 0, 3'd2, 64'h3002,   64'h0,        1, 64'h0,    0, 0, 64'h0,                 64'h0,      8'h00, 64'h0,                 64'h0,                 1);
    tbl[6]  = mk(1, 0, 3'd2, 64'h1004,   64'h0,        1, 64'h0,    1, 0, 64'h8765_4321_0000_0000, 64'h1000, 8'h00, 64'h0,                 64'hFFFF_FFFF_8765_4321, 0);
    tbl[7]  = mk(1, 0, 3'd6, 64'h1004,   64'h0,        1, 64'h0,    0, 1, 64'h8765_4321_0000_0000, 64'h1000, 8'h00, 64'h0,                 64'h0000_0000_8765_4321, 0);
    tbl[8]  = mk(1, 0, 3'd1, 64'h10,     64'h0,        1, 64'h0,    0, 0, 64'h0000_0000_0000_8001, 64'h10,   8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_8001, 0);
    tbl[9]  = mk(0, 1, 3'd0, 64'h5,      64'hAB,       1, 64'h0,    2, 1, 64'h0,                 64'h0,      8'h20, 64'h0000_AB00_0000_0000, 64'h0,               0);
    tbl[10] = mk(1, 0, 3'd7, 64'h18,     64'h0,        1, 64'h0,    0, 0, 64'hDEAD_BEEF_CAFE_F00D, 64'h18,   8'h00, 64'h0,                 64'hDEAD_BEEF_CAFE_F00D, 0);
    tbl[11] = mk(0, 0, 3'd0, 64'h0,      64'h0,        0, 64'h55,   0, 0, 64'h0,                 64'h0,      8'h00, 64'h0,                 64'h55,                0);
    tbl[12] = mk(0, 1, 3'd2, 64'h100C,   64'h1122_3344, 1, 64'h0,   0, 0, 64'h0,                 64'h1008,   8'hF0, 64'h1122_3344_0000_0000, 64'h0,               0);

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, issued back-to-back from each result cycle.
    for (int i = 0; i < 13; i++) do_op(tbl[i], $sformatf("vec%0d", i));

    // Pass-through followed by an idle cycle: enables drop, data holds.
    do_op(tbl[0], "pulse");
    @(posedge clk); #1;
    chk("pulse exe_ena_drop", {63'd0, rd_data_exe_ena}, 64'd0);
    chk("pulse exe_hold", rd_data_exe, 64'h1234);

    // Reset during RESP abandons the access; a late response is ignored.
    in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'd3; in_addr = 64'h40; in_rd_ena = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_load = 1'b0;
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    chk("rstresp in_resp", {62'd0, stall, req_valid}, 64'h2);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_mem = 64'd0; exp_exe = 64'd0;
    chk_all_zero("rstresp");
    rsp_valid = 1'b1; rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    chk("late_rsp ena", {63'd0, rd_data_mem_ena}, 64'd0);
    chk("late_rsp data", mem_r_data, 64'd0);
    chk("late_rsp stall", {62'd0, stall, req_valid}, 64'd0);

    // Randomized ops against the reference model.
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom % 3);
      r.load = (kind == 1); r.store = (kind == 2);
      r.f3 = r.store ? 3'($urandom % 4) : 3'($urandom % 8);
      r.addr = {$urandom, $urandom};
      n = m_nbytes(r.f3);
      if ($urandom % 4 != 0) r.addr = r.addr - (r.addr % n);
      off = int'(r.addr % 8);
      r.wdata = {$urandom, $urandom};
      r.rd_ena = 1'($urandom % 2);
      r.rd_data = {$urandom, $urandom};
      r.rdy_dly = int'($urandom % 4);
      r.rsp_dly = int'($urandom % 4);
      r.rdata = {$urandom, $urandom};
      r.exp_mis = (kind != 0) && ((r.addr % n) != 0);
      r.exp_addr = r.addr - (r.addr % 8);
      r.exp_wstrb = m_strb(r.f3, off);
      r.exp_wdata = r.wdata << (8 * off);
      r.exp_rd = (kind == 0) ? r.rd_data : m_load(r.f3, off, r.rdata);
      do_op(r, $sformatf("rnd%0d", t));
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
        chk("rnd idle_ena", {61'd0, rd_data_mem_ena, rd_data_exe_ena, misalign}, 64'd0);
        chk("rnd idle_mem_hold", mem_r_data, exp_mem);
        chk("rnd idle_exe_hold", rd_data_exe, exp_exe);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between execute and write-back in the 64-bit core. Takes one execute-stage op per cycle. Non-memory results pass straight through. Loads and stores go onto a single-outstanding valid/ready data bus, and the pipeline is stalled until the access completes. Registered outputs feed write-back's `rd_data_mem_ena`/`mem_r_data` and `rd_data_exe_ena`/`rd_data_exe` inputs directly.

## Interface
- `XLEN`, 64: data/address width (`REG_BUS`); only 64 is supported.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-low (`rst`==0 resets on the clock edge).
- `in_valid` input 1: execute presents an op this cycle.
- `in_load` input 1: op is a load.
- `in_store` input 1: op is a store. Never set together with `in_load`.
- `in_funct3` input 3: RV size/sign. 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `in_addr` input 64: effective byte address.
- `in_wdata` input 64: store data, LSB-aligned.
- `in_rd_ena` input 1: op writes rd.
- `in_rd_data` input 64: execute result for non-load ops.
- `stall` output 1: execute must hold its op. Combinational from state.
- `req_valid`, `req_wen` output 1: bus request; write when `req_wen`=1.
- `req_addr` output 64: `in_addr` with bits [2:0] forced to 0.
- `req_wdata` output 64, `req_wstrb` output 8: store data shifted to byte lane, byte enables.
- `req_ready` input 1: bus accepts request this cycle.
- `rsp_valid` input 1, `rsp_rdata` input 64: bus response; the 8-byte line containing the address.
- `rd_data_mem_ena` output 1, `mem_r_data` output 64: load result to write-back.
- `rd_data_exe_ena` output 1, `rd_data_exe` output 64: pass-through result to write-back.
- `misalign` output 1: one-cycle pulse on a misaligned access.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: `stall`=0.
  - Op with `in_valid`=1 and neither load nor store: register `rd_data_exe_ena`=`in_rd_ena` and `rd_data_exe`=`in_rd_data`. Remain IDLE.
  - Misaligned memory op (H addr[0]≠0, W addr[1:0]≠0, D addr[2:0]≠0): no bus access, `misalign` pulses, output enables 0. Remain IDLE.
  - Aligned load/store: latch addr, funct3, wdata, rd_ena and load/store. Go to REQ.
- REQ:
  - `req_valid`=1, `stall`=1, bus fields driven from latched values. Fields stay stable until `req_ready`.
  - `req_valid && req_ready`: go to RESP.
- RESP: `stall`=1.
  - On `rsp_valid`, a load registers `mem_r_data` = selected byte/half/word/dword at offset addr[2:0] of `rsp_rdata`. Signed sizes sign-extend to 64 bits; U sizes zero-extend. `rd_data_mem_ena`=latched rd_ena.
  - A store waits for `rsp_valid` (write ack), then writes nothing: `rd_data_mem_ena`=0.
  - Next state IDLE.
- Store lanes:
  - `req_wstrb` = (B 8'h01, H 8'h03, W 8'h0F, D 8'hFF) << addr[2:0].
  - `req_wdata` = `in_wdata` << (8·addr[2:0]).
- Output enables (`rd_data_mem_ena`, `rd_data_exe_ena`, `misalign`) are single-cycle: 0 in any cycle without a completing op. Data registers hold their last value.
- `rsp_valid` outside RESP is ignored. `req_ready` outside REQ is ignored.
- Reset (any state, including mid-access): state IDLE, all outputs 0, latched fields 0. An in-flight bus transaction is abandoned; the bus owner is reset by the same `rst`.
- Funct3 111 on a memory op is treated as D.

## Timing
- Pass-through op accepted at edge N: appears on `rd_data_exe*` in cycle N+1.
- Load/store accepted at edge N: `req_valid` is high from cycle N+1.
- Request handshake at edge R: RESP from R+1. `rsp_valid` at edge S: result/ack in cycle S+1, with `stall`=0 and IDLE in S+1.
- Minimum load latency is 3 cycles when ready and response arrive in the earliest cycles.
- `stall` is high in every REQ/RESP cycle; execute's inputs are don't-care while stalled.
- Back-to-back memory ops: the next op can be accepted in the same cycle the previous result is presented.

## Test plan
- Pass-through: `in_rd_ena`=1, `in_rd_data`=64'h1234 -> next cycle `rd_data_exe_ena`=1, `rd_data_exe`=64'h1234, `stall`=0.
- LB at addr 0x1003, `rsp_rdata`=64'h0000_0000_8000_0000 -> `req_addr`=0x1000, `mem_r_data`=64'hFFFF_FFFF_FFFF_FF80. Repeat with LBU -> 64'h80.
- SH at addr 0x2006, `in_wdata`=0xBEEF -> `req_wstrb`=8'hC0, `req_wdata`=64'hBEEF_0000_0000_0000, `req_wen`=1, `rd_data_mem_ena`=0 after ack.
- `req_ready` withheld 3 cycles and `rsp_valid` withheld 2 -> `req_*` stable throughout, `stall`=1 for every cycle until the result cycle, then IDLE.
- LW at addr 0x3002 -> `misalign`=1 for one cycle, `req_valid` never asserted, no enables.
- `rst`=0 during RESP -> next cycle all outputs 0 and IDLE. A late `rsp_valid` after reset produces no output.
